// File: rtl/fetcher.sv
// Instruction fetch: PC, direct-mapped one-word I-cache, single-word miss refill, static next-PC prediction.
// Build option: define STATIC_PREDICT_EN to predict JAL and backward branches as taken (otherwise pc+4).
module fetcher #(
  parameter int          ICACHE_SIZE = 256,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        dis_full_in,
  input  logic        rob_rollback_in,
  input  logic [31:0] rob_target_pc_in,
  output logic        mc_request_out,
  output logic [31:0] mc_addr_out,
  input  logic        mc_valid_in,
  input  logic [31:0] mc_data_in,
  output logic        fet_issue_out,
  output logic [31:0] fet_inst_out,
  output logic [31:0] fet_pc_out,
  output logic [31:0] fet_predict_pc_out
);

  localparam int IDX  = $clog2(ICACHE_SIZE);
  localparam int TAGW = 32 - IDX - 2;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:2]       req_addr_q, req_addr_d;
  logic              mc_req_q, mc_req_d;
  logic [31:2]       mc_addr_q, mc_addr_d;
  logic              issue_q, issue_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       ipc_q, ipc_d;
  logic [31:0]       ipred_q, ipred_d;

  logic [ICACHE_SIZE-1:0] valid_q;
  logic [TAGW-1:0]        tag_q  [ICACHE_SIZE];
  logic [31:0]            data_q [ICACHE_SIZE];

  logic [IDX-1:0]  pc_idx;
  logic [TAGW-1:0] pc_tag;
  logic [IDX-1:0]  fill_idx;
  logic            hit;
  logic [31:0]     cur_inst;
  logic [31:0]     pred_pc;
  logic            fill_en;

  assign pc_idx   = pc_q[IDX+1:2];
  assign pc_tag   = pc_q[31:IDX+2];
  assign fill_idx = req_addr_q[IDX+1:2];
  assign cur_inst = data_q[pc_idx];
  assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

`ifdef STATIC_PREDICT_EN
  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign imm_j = {{12{cur_inst[31]}}, cur_inst[19:12], cur_inst[20], cur_inst[30:21], 1'b0};
  assign imm_b = {{20{cur_inst[31]}}, cur_inst[7], cur_inst[30:25], cur_inst[11:8], 1'b0};

  always_comb begin
    pred_pc = pc_q + 32'd4;
    if (cur_inst[6:0] == 7'b1101111) begin
      pred_pc = pc_q + imm_j;
    end else if (cur_inst[6:0] == 7'b1100011 && cur_inst[31]) begin
      pred_pc = pc_q + imm_b;
    end
  end
`else
  assign pred_pc = pc_q + 32'd4;
`endif

  // Rollback only redirects pc; an outstanding refill still completes into req_addr's entry.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    mc_req_d   = mc_req_q;
    mc_addr_d  = mc_addr_q;
    issue_d    = 1'b0;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    ipred_d    = ipred_q;
    fill_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rob_rollback_in) begin
          pc_d = rob_target_pc_in;
        end else if (hit) begin
          if (!dis_full_in) begin
            issue_d = 1'b1;
            inst_d  = cur_inst;
            ipc_d   = pc_q;
            ipred_d = pred_pc;
            pc_d    = pred_pc;
          end
        end else begin
          mc_req_d   = 1'b1;
          mc_addr_d  = pc_q[31:2];
          req_addr_d = pc_q[31:2];
          state_d    = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (mc_valid_in) begin
          fill_en  = 1'b1;
          mc_req_d = 1'b0;
          state_d  = IDLE;
        end
        if (rob_rollback_in) begin
          pc_d = rob_target_pc_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
      issue_q    <= 1'b0;
      inst_q     <= '0;
      ipc_q      <= '0;
      ipred_q    <= '0;
      valid_q    <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
      issue_q    <= issue_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      ipred_q    <= ipred_d;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid vector alone qualifies them.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill_en) begin
      tag_q[fill_idx]  <= req_addr_q[31:IDX+2];
      data_q[fill_idx] <= mc_data_in;
    end
  end

  assign mc_request_out     = mc_req_q;
  assign mc_addr_out        = {mc_addr_q, 2'b00};
  assign fet_issue_out      = issue_q & rdy_in;
  assign fet_inst_out       = inst_q;
  assign fet_pc_out         = ipc_q;
  assign fet_predict_pc_out = ipred_q;

endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch stage of the Tomasulo core, and the producer that drives the Decoder's `fet_*` inputs. It keeps the PC and looks it up in a direct-mapped instruction cache. On a miss it refills one word through a request/valid handshake with the memory controller. On a hit it issues one instruction per cycle with a statically predicted next PC, and it redirects to the ROB-supplied target on rollback.

## Interface
- `ICACHE_SIZE`, default 256: number of one-word entries; power of two; `IDX = log2(ICACHE_SIZE)`.
- `RESET_PC`, default 32'h0: PC value after reset.

Ports:
- `clk_in` input 1: clock.
- `rst_in` input 1: reset; synchronous, active-high.
- `rdy_in` input 1: global enable; when low, all state and outputs hold.
- `dis_full_in` input 1: any of RS/LSB/ROB cannot accept an instruction this cycle.
- `rob_rollback_in` input 1: misprediction flush.
- `rob_target_pc_in` input 32: correct PC, valid with `rob_rollback_in`.
- `mc_request_out` output 1: word-read request, level.
- `mc_addr_out` output 32: request address, word aligned.
- `mc_valid_in` input 1: one-cycle pulse; read data valid.
- `mc_data_in` input 32: returned instruction word.
- `fet_issue_out` output 1: one-cycle pulse; instruction valid to Decoder/ROB.
- `fet_inst_out` output 32: instruction word.
- `fet_pc_out` output 32: its PC.
- `fet_predict_pc_out` output 32: predicted next PC.

## Operation
- Cache geometry:
  - Index is `pc[IDX+1:2]`; tag is `pc[31:IDX+2]`.
  - Each entry holds a valid bit, the tag and a 32-bit instruction.
  - All valid bits clear on reset. Data and tag arrays are not reset.
- State machine:
  - `IDLE`, hit, `!dis_full_in`, `!rob_rollback_in`:
    - Register the issue outputs (inst, pc, predicted pc) and assert `fet_issue_out` for the next cycle.
    - Set `pc <= predict_pc`. Stay in `IDLE`.
  - `IDLE`, hit, `dis_full_in`: no issue; pc holds.
  - `IDLE`, miss, no rollback:
    - Set `mc_request_out <= 1`, `mc_addr_out <= pc`, `req_addr <= pc`.
    - Go to `WAIT_MEM`.
  - `WAIT_MEM`, `mc_valid_in`:
    - Write `mc_data_in` into the entry for `req_addr`; set valid.
    - Set `mc_request_out <= 0`. Go to `IDLE`.
    - No issue in this cycle. The following `IDLE` cycle hits if pc is unchanged.
  - `WAIT_MEM`, otherwise: request held; address stable.
- Rollback, any state:
  - `pc <= rob_target_pc_in`. No issue in the following cycle.
  - Rollback takes priority over hit/issue and over miss-request start.
  - In `WAIT_MEM` the outstanding request is not aborted. It completes normally and fills the cache for `req_addr`; the FSM then returns to `IDLE` at the new pc.
  - If rollback and `mc_valid_in` coincide, both take effect.
- Prediction (see Configuration):
  - Opcode 1101111 (JAL): `pc + immJ`.
  - Opcode 1100011 (branch) with `inst[31]==1` (backward): `pc + immB`.
  - All other opcodes, including JALR and forward branches: `pc + 4`.
  - All adds are 32-bit modulo 2^32 (wrap-around).
  - `immJ` and `immB` are the sign-extended RV32I J/B-type immediates, with bit 0 = 0.

## Timing
- Reset values:
  - `fet_issue_out = 0`; `fet_inst_out`, `fet_pc_out`, `fet_predict_pc_out` = 0.
  - `mc_request_out = 0`, `mc_addr_out = 0`.
  - `pc = RESET_PC`, state `IDLE`, all valid bits = 0.
- Reset mid-`WAIT_MEM`:
  - Returns to `IDLE` and drops the request.
  - The memory controller is reset in the same cycle, so no late `mc_valid_in` is expected.
- Hit latency: decision in cycle N; `fet_issue_out` high in cycle N+1. Sustained rate is 1 instruction/cycle.
- Miss latency: request visible in cycle N+1. With fill at `mc_valid_in` in cycle M, the first issue is in cycle M+2.
- `fet_issue_out` is always a single-cycle pulse. Its data outputs are stable only while it is high.
- `dis_full_in` is sampled at the decision edge. An instruction issued in N+1 was accepted under `!dis_full_in` in N.
- `rdy_in` low freezes the FSM, pc and all outputs. `fet_issue_out` is forced to 0 while `rdy_in` is low.

## Configuration
- `STATIC_PREDICT_EN`:
  - Defined: JAL and backward-branch prediction as above.
  - Undefined: `fet_predict_pc_out = fet_pc_out + 4` for every instruction; the ROB corrects every taken control transfer via rollback.

## Test plan
- Cold start, `RESET_PC=0`, memory word 0 = 32'h00100093 (addi x1,x0,1):
  - `mc_request_out` goes high with `mc_addr_out=0`.
  - After `mc_valid_in`, `fet_issue_out` pulses with inst 32'h00100093, pc 0, predict 4.
- Straight-line hits: 4 words preloaded at 0..12.
  - Four consecutive `fet_issue_out` pulses with pc 0, 4, 8, 12.
  - Repeat with `dis_full_in` held high for 3 cycles mid-stream: no pulses, no pc skip.
- Prediction, `STATIC_PREDICT_EN` on:
  - JAL +16 at pc 0x20 → predict 0x30.
  - BEQ −8 at 0x40 → predict 0x38.
  - BNE +8 at 0x50 → predict 0x54.
  - With the macro off, all three predict pc+4.
- Rollback during `WAIT_MEM`: miss at 0x100, `rob_rollback_in` with target 0x200 before `mc_valid_in`.
  - No issue of 0x100.
  - The 0x100 entry is filled.
  - Next request is for 0x200.
- Conflict and wrap:
  - With `ICACHE_SIZE=256`, pc 0x0 and 0x400 share an index. Fetching 0x400 after 0x0 misses and refills.
  - JAL at 32'hFFFFFFFC with offset +8 predicts 32'h00000004.
